// File: rtl/stats_acc_lane.sv
// rtl/stats_acc_lane.sv - per-channel increment accumulator with clear-and-keep-increment
module stats_acc_lane #(
  parameter int INC_WIDTH = 8,
  parameter int ACC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 valid,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [ACC_WIDTH-1:0] inc_ext;

  assign inc_ext = ACC_WIDTH'(inc);

  // A clear still captures the same-cycle increment so nothing is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= valid ? inc_ext : '0;
    end else if (valid) begin
      acc <= acc + inc_ext;
    end
  end

endmodule

// File: rtl/stats_collect_flush.sv
// rtl/stats_collect_flush.sv - multi-channel statistics accumulator with periodic update and flush
module stats_collect_flush #(
  parameter int COUNT          = 8,
  parameter int INC_WIDTH      = 8,
  parameter int STAT_INC_WIDTH = 16,
  parameter int ID_BASE        = 0,
  parameter int STAT_ID_WIDTH  = $clog2(COUNT + ID_BASE),
  parameter int UPDATE_PERIOD  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INC_WIDTH*COUNT-1:0]   stat_inc,
  input  logic [COUNT-1:0]             stat_valid,
  input  logic [COUNT-1:0]             stat_mask,
  output logic [STAT_INC_WIDTH-1:0]    m_axis_stat_tdata,
  output logic [STAT_ID_WIDTH-1:0]     m_axis_stat_tid,
  output logic                         m_axis_stat_tvalid,
  input  logic                         m_axis_stat_tready,
  input  logic                         update,
  input  logic                         flush,
  output logic                         flush_done,
  output logic                         busy
);

  localparam int ACC_WIDTH = INC_WIDTH + $clog2(COUNT) + 1;
  localparam int CH_W      = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int SUM_W     = ((ACC_WIDTH > STAT_INC_WIDTH) ? ACC_WIDTH : STAT_INC_WIDTH) + 1;
  localparam int PER_W     = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [STAT_INC_WIDTH-1:0] STAT_MAX = '1;

  typedef enum logic {S_READ, S_WRITE} scan_t;

  scan_t                       state;
  logic [CH_W-1:0]             ch;
  logic [STAT_INC_WIDTH-1:0]   mem [COUNT];
  logic [STAT_INC_WIDTH-1:0]   word;
  logic [ACC_WIDTH-1:0]        acc [COUNT];
  logic [COUNT-1:0]            zero;
  logic [COUNT-1:0]            upd;
  logic [COUNT-1:0]            flsh;
  logic [COUNT-1:0]            lane_clear;
  logic [COUNT-1:0]            emit_clear;
  logic [PER_W-1:0]            period;
  logic [STAT_INC_WIDTH-1:0]   eff_word;
  logic [SUM_W-1:0]            sum_wide;
  logic [STAT_INC_WIDTH-1:0]   sum;
  logic                        in_write;
  logic                        slot_free;
  logic                        emit;
  logic                        upd_set;
  logic                        done_cond;

  for (genvar n = 0; n < COUNT; n++) begin : g_lane
    stats_acc_lane #(
      .INC_WIDTH (INC_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .inc   (stat_inc[n*INC_WIDTH +: INC_WIDTH]),
      .valid (stat_valid[n] & stat_mask[n]),
      .clear (lane_clear[n]),
      .acc   (acc[n])
    );
  end

  // Storage has no reset; the zero flags hide stale contents until first written.
  assign in_write   = (state == S_WRITE);
  assign eff_word   = zero[ch] ? '0 : word;
  assign sum_wide   = SUM_W'(eff_word) + SUM_W'(acc[ch]);
  assign sum        = (sum_wide > SUM_W'(STAT_MAX)) ? STAT_MAX : sum_wide[STAT_INC_WIDTH-1:0];
  assign slot_free  = !m_axis_stat_tvalid || m_axis_stat_tready;
  assign emit       = in_write && slot_free &&
                      (upd[ch] || flsh[ch] || eff_word[STAT_INC_WIDTH-1]);
  assign lane_clear = in_write ? (COUNT'(1) << ch) : '0;
  assign emit_clear = emit ? lane_clear : '0;
  assign upd_set    = (period == '0) || update;
  assign done_cond  = busy && !flush && (flsh == '0) && slot_free;

  always_ff @(posedge clk) begin
    if (state == S_READ) begin
      word <= mem[ch];
    end else begin
      mem[ch] <= emit ? '0 : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_READ;
      ch                 <= '0;
      zero               <= '1;
      upd                <= '0;
      flsh               <= '0;
      period             <= PER_W'(UPDATE_PERIOD - 1);
      m_axis_stat_tvalid <= 1'b0;
      m_axis_stat_tdata  <= '0;
      m_axis_stat_tid    <= '0;
      flush_done         <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state <= in_write ? S_READ : S_WRITE;
      if (in_write) begin
        ch <= (ch == CH_W'(COUNT - 1)) ? '0 : ch + 1'b1;
      end
      zero   <= zero & ~lane_clear;
      period <= upd_set ? PER_W'(UPDATE_PERIOD - 1) : period - 1'b1;
      // Set requests win over a same-cycle emit clear.
      upd    <= (upd & ~emit_clear) | {COUNT{upd_set}};
      flsh   <= (flsh & ~emit_clear) | {COUNT{flush}};
      if (emit) begin
        m_axis_stat_tvalid <= (sum != '0);
        m_axis_stat_tdata  <= sum;
        m_axis_stat_tid    <= STAT_ID_WIDTH'(ID_BASE + int'(ch));
      end else if (m_axis_stat_tready) begin
        m_axis_stat_tvalid <= 1'b0;
      end
      flush_done <= done_cond;
      busy       <= flush || (busy && !done_cond);
    end
  end

endmodule

// File: tb/tb_stats_collect_flush.sv
// tb/tb_stats_collect_flush.sv - directed self-checking bench for stats_collect_flush
module tb_stats_collect_flush;

  localparam int COUNT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stat_inc;
  logic [3:0]  stat_valid;
  logic [3:0]  stat_mask;
  logic        tready;
  logic        update;
  logic        flush;
  logic [15:0] tdata;
  logic [3:0]  tid;
  logic        tvalid;
  logic        flush_done;
  logic        busy;
  logic [15:0] l_tdata;
  logic [3:0]  l_tid;
  logic        l_tvalid;
  logic        l_flush_done;
  logic        l_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int lfd_count = 0;
  logic [19:0] beats[$];
  int          bcyc[$];
  logic [19:0] lbeats[$];

  stats_collect_flush #(
    .COUNT(4), .INC_WIDTH(8), .STAT_INC_WIDTH(16), .ID_BASE(8), .UPDATE_PERIOD(64)
  ) dut (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid), .stat_mask(stat_mask),
    .m_axis_stat_tdata(tdata), .m_axis_stat_tid(tid), .m_axis_stat_tvalid(tvalid),
    .m_axis_stat_tready(tready), .update(update), .flush(flush),
    .flush_done(flush_done), .busy(busy)
  );

  // Long-period copy so the word-MSB early emit is reachable before any timed update.
  stats_collect_flush #(
    .COUNT(4), .INC_WIDTH(8), .STAT_INC_WIDTH(16), .ID_BASE(8), .UPDATE_PERIOD(4096)
  ) dut_long (
    .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid), .stat_mask(stat_mask),
    .m_axis_stat_tdata(l_tdata), .m_axis_stat_tid(l_tid), .m_axis_stat_tvalid(l_tvalid),
    .m_axis_stat_tready(tready), .update(update), .flush(flush),
    .flush_done(l_flush_done), .busy(l_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid && tready) begin
      beats.push_back({tid, tdata});
      bcyc.push_back(cyc);
    end
    if (flush_done) begin
      fd_count = fd_count + 1;
      fd_cyc = cyc;
    end
    if (l_tvalid && tready) lbeats.push_back({l_tid, l_tdata});
    if (l_flush_done) lfd_count = lfd_count + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    beats.delete();
    bcyc.delete();
    lbeats.delete();
    fd_count = 0;
    lfd_count = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    stat_inc = '0;
    stat_valid = '0;
    stat_mask = '1;
    tready = 1'b1;
    update = 1'b0;
    flush = 1'b0;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
    repeat (20) tick();
    n_cmp++; if (beats.size() != 0) begin n_bad++; $display("FAIL idle_beats got=%0d exp=0", beats.size()); end
  endtask

  task automatic test_update;
    int t0;
    do_reset();
    stat_inc[2*8 +: 8] = 8'd5;
    stat_valid = 4'b0100;
    repeat (10) tick();
    stat_valid = '0;
    update = 1'b1;
    t0 = cyc;
    tick();
    update = 1'b0;
    repeat (12) tick();
    n_cmp++; if (beats.size() != 1) begin n_bad++; $display("FAIL upd_count got=%0d exp=1", beats.size()); end
    n_cmp++;
    if (beats.size() < 1 || beats[0] !== {4'd10, 16'd50}) begin
      n_bad++; $display("FAIL upd_beat got=%h exp=%h", (beats.size() > 0) ? beats[0] : 20'hx, {4'd10, 16'd50});
    end
    n_cmp++;
    if (bcyc.size() < 1 || (bcyc[0] - t0) > 2*COUNT + 2) begin
      n_bad++; $display("FAIL upd_latency got=%0d exp<=%0d", (bcyc.size() > 0) ? bcyc[0] - t0 : -1, 2*COUNT + 2);
    end
  endtask

  task automatic test_msb_early;
    int n;
    int k;
    int total;
    do_reset();
    stat_inc[7:0] = 8'd255;
    stat_valid = 4'b0001;
    n = 0;
    while (lbeats.size() == 0 && n < 400) begin
      tick();
      n++;
    end
    stat_valid = '0;
    n_cmp++; if (lbeats.size() != 1) begin n_bad++; $display("FAIL msb_emit got=%0d beats exp=1 after %0d cycles", lbeats.size(), n); end
    n_cmp++;
    if (lbeats.size() < 1 || lbeats[0][19:16] !== 4'd8 || lbeats[0][15:0] < 16'h8000) begin
      n_bad++; $display("FAIL msb_beat got=%h exp=tid 8 tdata>=8000", (lbeats.size() > 0) ? lbeats[0] : 20'hx);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (lfd_count == 0 && k < 100) begin
      tick();
      k++;
    end
    n_cmp++; if (lfd_count != 1) begin n_bad++; $display("FAIL msb_flush_done got=%0d exp=1", lfd_count); end
    total = 0;
    foreach (lbeats[i]) total += int'(lbeats[i][15:0]);
    n_cmp++; if (total != 255 * n) begin n_bad++; $display("FAIL msb_total got=%0d exp=%0d", total, 255 * n); end
  endtask

  task automatic test_backpressure;
    int k;
    logic bad;
    do_reset();
    tready = 1'b0;
    stat_inc[7:0] = 8'd3;
    stat_inc[15:8] = 8'd7;
    stat_valid = 4'b0011;
    tick();
    stat_valid = '0;
    repeat (6) tick();
    update = 1'b1;
    tick();
    update = 1'b0;
    k = 0;
    while (!tvalid && k < 20) begin
      tick();
      k++;
    end
    bad = 1'b0;
    repeat (16) begin
      if (tvalid !== 1'b1 || tid !== 4'd8 || tdata !== 16'd3) bad = 1'b1;
      tick();
    end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL bp_hold got=%b/%h/%h exp=1/8/0003", tvalid, tid, tdata); end
    n_cmp++; if (beats.size() != 0) begin n_bad++; $display("FAIL bp_no_accept got=%0d exp=0", beats.size()); end
    tready = 1'b1;
    repeat (12) tick();
    n_cmp++; if (beats.size() != 2) begin n_bad++; $display("FAIL bp_count got=%0d exp=2", beats.size()); end
    n_cmp++;
    if (beats.size() < 2 || beats[0] !== {4'd8, 16'd3} || beats[1] !== {4'd9, 16'd7}) begin
      n_bad++; $display("FAIL bp_beats got=%h,%h exp=80003,90007",
                        (beats.size() > 0) ? beats[0] : 20'hx, (beats.size() > 1) ? beats[1] : 20'hx);
    end
  endtask

  task automatic test_flush;
    int k;
    do_reset();
    stat_inc[3*8 +: 8] = 8'd9;
    stat_valid = 4'b1000;
    repeat (4) tick();
    stat_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy got=%b exp=1", busy); end
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (fd_count == 0 && k < 60) begin
      tick();
      k++;
    end
    repeat (10) tick();
    n_cmp++; if (fd_count != 1) begin n_bad++; $display("FAIL flush_done_count got=%0d exp=1", fd_count); end
    n_cmp++;
    if (beats.size() != 1 || beats[0] !== {4'd11, 16'd36}) begin
      n_bad++; $display("FAIL flush_beat got=%0d beats first=%h exp=1 beat b0024",
                        beats.size(), (beats.size() > 0) ? beats[0] : 20'hx);
    end
    n_cmp++;
    if (bcyc.size() < 1 || bcyc[0] >= fd_cyc) begin
      n_bad++; $display("FAIL flush_order got=beat@%0d done@%0d exp=beat first", (bcyc.size() > 0) ? bcyc[0] : -1, fd_cyc);
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_mask;
    int k;
    do_reset();
    stat_mask = 4'b1101;
    stat_inc[15:8] = 8'd4;
    stat_valid = 4'b0010;
    repeat (20) tick();
    stat_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (fd_count == 0 && k < 60) begin
      tick();
      k++;
    end
    n_cmp++; if (fd_count != 1) begin n_bad++; $display("FAIL mask_flush_done got=%0d exp=1", fd_count); end
    n_cmp++; if (beats.size() != 0) begin n_bad++; $display("FAIL mask_beats got=%0d exp=0", beats.size()); end
  endtask

  task automatic test_reset_mid;
    int k;
    do_reset();
    tready = 1'b0;
    stat_inc[7:0] = 8'd6;
    stat_valid = 4'b0001;
    tick();
    stat_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    k = 0;
    while (!tvalid && k < 20) begin
      tick();
      k++;
    end
    n_cmp++; if (tvalid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rm_pre got=%b%b exp=11", tvalid, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
    n_cmp++; if (tvalid !== 1'b0) begin n_bad++; $display("FAIL rm_tvalid got=%b exp=0", tvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    tready = 1'b1;
    repeat (20) tick();
    n_cmp++; if (fd_count != 0) begin n_bad++; $display("FAIL rm_flush_done got=%0d exp=0", fd_count); end
    stat_inc[15:8] = 8'd2;
    stat_valid = 4'b0010;
    tick();
    stat_valid = '0;
    update = 1'b1;
    tick();
    update = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if (beats.size() != 1 || beats[0] !== {4'd9, 16'd2}) begin
      n_bad++; $display("FAIL rm_post got=%0d beats first=%h exp=1 beat 90002",
                        beats.size(), (beats.size() > 0) ? beats[0] : 20'hx);
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_msb_early();
    test_backpressure();
    test_flush();
    test_mask();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stats_collect_flush.md
STATS_COLLECT_FLUSH -- requirements
Module: stats_collect_flush

Interface
REQ-001 Parameter COUNT, default 8: number of increment channels.
REQ-002 Parameter INC_WIDTH, default 8: per-channel increment width (bits).
REQ-003 Parameter STAT_INC_WIDTH, default 16: output increment and storage word width (bits).
REQ-004 Parameter STAT_ID_WIDTH, default $clog2(COUNT+ID_BASE): output ID width (bits).
REQ-005 Parameter ID_BASE, default 0: constant added to the channel index to form the output ID.
REQ-006 Parameter UPDATE_PERIOD, default 1024: cycles between automatic update sweeps.
REQ-007 Ports, in order:
- clk  in  1  clock; one clock domain; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- stat_inc  in  INC_WIDTH*COUNT  per-channel increments; channel n at bits [n*INC_WIDTH +: INC_WIDTH].
- stat_valid  in  COUNT  per-channel increment qualifiers.
- stat_mask  in  COUNT  1 = channel enabled; increments on a masked channel are discarded.
- m_axis_stat_tdata  out  STAT_INC_WIDTH  accumulated increment.
- m_axis_stat_tid  out  STAT_ID_WIDTH  ID_BASE + channel index.
- m_axis_stat_tvalid  out  1  output valid.
- m_axis_stat_tready  in  1  output ready.
- update  in  1  pulse: request an update sweep of all channels.
- flush  in  1  pulse: request a flush of all channels.
- flush_done  out  1  one-cycle pulse when a flush completes.
- busy  out  1  high while a flush is pending.

Function
REQ-010 Each channel has an accumulator ACC_WIDTH = INC_WIDTH+$clog2(COUNT)+1. When stat_valid[n] && stat_mask[n], the accumulator adds stat_inc[n] every cycle.
REQ-011 A two-state scan (READ, WRITE) visits channels 0..COUNT-1 cyclically. It wraps from COUNT-1 to 0, so each channel is visited every 2*COUNT cycles.
REQ-012 READ: storage word[ch] is registered. WRITE: the accumulator is cleared, keeping any same-cycle increment (the accumulator is loaded with that increment instead of 0). The next state is READ.
REQ-013 sum = (zero[ch] ? 0 : word[ch]) + acc[ch], saturating at 2^STAT_INC_WIDTH-1. zero[ch] clears on the first WRITE visit to ch.
REQ-014 Emit condition in WRITE: output slot free (!tvalid || tready) AND (upd[ch] OR flsh[ch] OR word MSB set).
- On emit: word[ch] is written 0, upd[ch] and flsh[ch] clear, tdata=sum, tid=ID_BASE+ch.
- tvalid = (sum != 0) on emit.
- Otherwise word[ch] is written sum.
REQ-015 If the slot is not free, the emit is deferred to the channel's next visit; the pending bits stay set.
REQ-016 While tvalid && !tready, tdata and tid hold stable. tvalid deasserts after a tready handshake unless a new emit occurs in that same cycle.
REQ-017 A period counter reloads to UPDATE_PERIOD-1 and sets all upd bits when it reaches 0 or when update is asserted; otherwise it decrements each cycle.
REQ-018 flush sets all flsh bits and busy. flush arriving during a pending flush re-arms all bits, and only one flush_done is issued.
REQ-019 flush_done pulses for 1 cycle in the first cycle where all flsh bits are clear and no output beat is held (tvalid low, or handshake completing); busy clears in the same cycle.
REQ-020 Bits set by update/flush in the same cycle as a WRITE clear of that channel remain set (the set wins).
REQ-021 Masked channels are still scanned and still emit their stored residue; no new increments accumulate on them.

Reset
REQ-030 rst asserted for one or more cycles SHALL produce, on the next edge:
- accumulators 0, storage zero flags all 1, upd/flsh bits 0;
- scan in READ at channel 0, period counter UPDATE_PERIOD-1;
- m_axis_stat_tvalid 0, flush_done 0, busy 0.
REQ-031 Reset mid-flush or mid-handshake abandons the flush and the held beat with no flush_done; tdata/tid are don't-care.

Structure
REQ-040 No shared package; scan state encoding and ACC_WIDTH are module-local localparams.
REQ-041 Per-channel accumulator is sub-module stats_acc_lane (INC_WIDTH, ACC_WIDTH; ports clk, rst, inc, valid, clear, acc), instantiated COUNT times in a generate loop.
REQ-042 Storage is a COUNT-deep, STAT_INC_WIDTH-wide array with one access per cycle (read in READ, write in WRITE), inferable as distributed RAM.

Verification (COUNT=4, INC_WIDTH=8, STAT_INC_WIDTH=16, ID_BASE=8, UPDATE_PERIOD=64, tready=1 unless stated)
REQ-050 Stimulus: stat_inc ch2 = 5 for 10 cycles, then update. Response: one beat tid=10, tdata=50 within 2*COUNT+2 cycles; no beats for other channels.
REQ-051 Stimulus: inc ch0 = 255 every cycle, no update/flush. Response: when word MSB is set, an early emit occurs with tdata >= 0x8000; beat tdata values summed equal total injected once flushed.
REQ-052 Stimulus: tready=0 with upd set on ch0 and ch1 (values 3, 7). Response: beat tid=8, tdata=3 held stable; ch1 is deferred and emits 7 after tready rises; no data lost.
REQ-053 Stimulus: inc ch3 = 9 for 4 cycles, then flush; second flush 3 cycles later. Response: busy high; exactly one flush_done after beat tid=11, tdata=36 completes.
REQ-054 Stimulus: stat_mask[1]=0 with inc ch1 = 4 for 20 cycles, then flush. Response: no beat with tid=9; flush_done still pulses.
REQ-055 Stimulus: rst for 1 cycle while tvalid=1 and busy=1. Response: next cycle tvalid=0, busy=0, flush_done never pulses; the next update emits only post-reset increments.
